// File: rtl/seg7_scan_driver.sv
// Scans four BCD digits onto a 4-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame, and every digit slot is followed by an all-off slot.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST   = BCW'(BLINK_HALF - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [RCW-1:0]   refresh_cnt;
  logic [BCW-1:0]   blink_cnt;
  logic             blink_phase;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      dig_snap;
  logic [3:0]       blink_snap;
  logic [3:0]       dp_snap;

  logic             tick;
  logic             blink_wrap;
  logic             frame_tick;
  logic [3:0]       cur_dig;
  logic [3:0]       an_p0;
  logic [6:0]       seg_p0;
  logic             dp_p0;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick       = (refresh_cnt == REFRESH_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  // The frame boundary is the BLANK tick that wraps the digit index back to 0.
  assign frame_tick = tick && (state == BLANK) && (idx == 2'd3);
  assign cur_dig    = dig_snap[{idx, 2'b00} +: 4];

  // Slot and blink timebases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap)
        blink_phase <= ~blink_phase;
    end
  end

  // Per-frame input snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_snap   <= '0;
      blink_snap <= '0;
      dp_snap    <= '0;
    end else if (frame_tick) begin
      dig_snap   <= digits;
      blink_snap <= blink_mask;
      dp_snap    <= dp_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BLANK;
      idx   <= 2'd3;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state and next display values; every tick cycle forces the display dark.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    an_p0     = 4'b1111;
    seg_p0    = 7'h7F;
    dp_p0     = 1'b1;
    case (state)
      BLANK: begin
        if (tick) begin
          state_nxt = SHOW;
          idx_nxt   = idx + 2'd1;
        end
      end
      SHOW: begin
        if (tick) begin
          state_nxt = BLANK;
        end else begin
          an_p0  = (blink_phase && blink_snap[idx]) ? 4'b1111 : ~(4'b0001 << idx);
          seg_p0 = bcd_to_seg(cur_dig);
          dp_p0  = ~dp_snap[idx];
        end
      end
      default: begin
        state_nxt = BLANK;
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_p0;
      seg        <= seg_p0;
      dp         <= dp_p0;
      frame_done <= frame_tick;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_HALF=32.
// k counts rising edges since reset release; outputs are sampled on the falling edge after edge k.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .REFRESH_DIV(4),
    .BLINK_HALF (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .digits    (digits),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct {
    int          k;
    logic [15:0] d;
    logic [3:0]  bm;
    logic [3:0]  dpm;
  } in_t;

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  task automatic chk_all(input int k, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic e_fd);
    chk("an",         k, {4'h0, an},         {4'h0, e_an});
    chk("seg",        k, {1'b0, seg},        {1'b0, e_seg});
    chk("dp",         k, {7'h0, dp},         {7'h0, e_dp});
    chk("frame_done", k, {7'h0, frame_done}, {7'h0, e_fd});
  endtask

  exp_t ev[$];
  in_t  iv[$];

  initial begin
    ev = '{
      '{3,   4'hF, 7'h7F, 1'b1, 1'b0},
      '{4,   4'hF, 7'h7F, 1'b1, 1'b1},
      '{5,   4'hE, 7'h19, 1'b1, 1'b0},
      '{7,   4'hE, 7'h19, 1'b1, 1'b0},
      '{8,   4'hF, 7'h7F, 1'b1, 1'b0},
      '{12,  4'hF, 7'h7F, 1'b1, 1'b0},
      '{13,  4'hD, 7'h30, 1'b1, 1'b0},
      '{21,  4'hB, 7'h24, 1'b1, 1'b0},
      '{29,  4'h7, 7'h79, 1'b1, 1'b0},
      '{32,  4'hF, 7'h7F, 1'b1, 1'b0},
      '{35,  4'hF, 7'h7F, 1'b1, 1'b0},
      '{36,  4'hF, 7'h7F, 1'b1, 1'b1},
      '{37,  4'hF, 7'h00, 1'b1, 1'b0},
      '{39,  4'hF, 7'h00, 1'b1, 1'b0},
      '{45,  4'hD, 7'h78, 1'b1, 1'b0},
      '{53,  4'hB, 7'h02, 1'b1, 1'b0},
      '{61,  4'h7, 7'h12, 1'b1, 1'b0},
      '{68,  4'hF, 7'h7F, 1'b1, 1'b1},
      '{69,  4'hE, 7'h00, 1'b1, 1'b0},
      '{77,  4'hD, 7'h7F, 1'b0, 1'b0},
      '{79,  4'hD, 7'h7F, 1'b0, 1'b0},
      '{80,  4'hF, 7'h7F, 1'b1, 1'b0},
      '{81,  4'hF, 7'h7F, 1'b1, 1'b0},
      '{85,  4'hB, 7'h02, 1'b1, 1'b0},
      '{93,  4'h7, 7'h12, 1'b1, 1'b0},
      '{100, 4'hF, 7'h7F, 1'b1, 1'b1},
      '{101, 4'hF, 7'h00, 1'b1, 1'b0},
      '{109, 4'hD, 7'h7F, 1'b0, 1'b0},
      '{133, 4'hE, 7'h00, 1'b1, 1'b0},
      '{165, 4'hE, 7'h00, 1'b1, 1'b0},
      '{173, 4'hD, 7'h7F, 1'b0, 1'b0},
      '{181, 4'hB, 7'h02, 1'b1, 1'b0},
      '{182, 4'hB, 7'h02, 1'b1, 1'b0}
    };
    // Input changes are applied after the sample at the same k.
    iv = '{
      '{14,  16'h5678, 4'b0000, 4'b0000},
      '{30,  16'h5678, 4'b0001, 4'b0000},
      '{40,  16'h56A8, 4'b0001, 4'b0010},
      '{100, 16'h56A8, 4'b0000, 4'b0010}
    };

    reset_n    = 1'b0;
    digits     = 16'h1234;
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;

    repeat (3) @(negedge clk);
    chk_all(0, 4'hF, 7'h7F, 1'b1, 1'b0);
    reset_n = 1'b1;

    begin
      int ei = 0;
      int ii = 0;
      for (int k = 1; k <= 182; k++) begin
        @(negedge clk);
        if (ei < ev.size() && ev[ei].k == k) begin
          chk_all(k, ev[ei].an, ev[ei].seg, ev[ei].dp, ev[ei].fd);
          ei++;
        end
        if (ii < iv.size() && iv[ii].k == k) begin
          digits     = iv[ii].d;
          blink_mask = iv[ii].bm;
          dp_mask    = iv[ii].dpm;
          ii++;
        end
      end
    end

    // Reset pulse during the digit-2 slot: outputs clear without a clock edge.
    reset_n = 1'b0;
    #1;
    chk_all(-1, 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    chk_all(-2, 4'hF, 7'h7F, 1'b1, 1'b0);
    reset_n = 1'b1;

    // Startup repeats from digit 0 using the current inputs (56A8, dp on digit 1).
    repeat (3) @(negedge clk);
    chk_all(1003, 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    chk_all(1004, 4'hF, 7'h7F, 1'b1, 1'b1);
    @(negedge clk);
    chk_all(1005, 4'hE, 7'h00, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk_all(1013, 4'hD, 7'h7F, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
